// File: rtl/ldpc_layered_oms_decoder.sv
// Layered offset-min-sum LDPC decoder for any M x N parity-check matrix.
// Check rows are processed serially (SCAN then UPD per row), with a syndrome check after every iteration.
module ldpc_layered_oms_decoder #(
    parameter int             M        = 2,
    parameter int             N        = 4,
    parameter logic [M*N-1:0] H_MATRIX = 8'b1110_1011,
    parameter int             LLR_W    = 6,
    parameter int             GAMMA_W  = 8,
    parameter int             MSG_W    = 5,
    parameter int             OFFSET   = 1,
    parameter int             MAX_ITER = 10,
    parameter int             ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              llr_valid,
    output logic              llr_ready,
    input  logic [LLR_W-1:0]  llr_in,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic [N-1:0]      codeword,
    output logic [ITER_W-1:0] iterations,
    output logic              converged,
    output logic              busy
);

    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int RW    = (M > 1) ? $clog2(M) : 1;
    localparam int MAG_W = MSG_W - 1;
    localparam logic [MAG_W-1:0] MAX_MAG = {MAG_W{1'b1}};
    localparam logic [MAG_W-1:0] OFF_V   = MAG_W'(OFFSET);
    localparam int G_LIM = (1 << (GAMMA_W - 1)) - 1;
    localparam logic signed [GAMMA_W:0] G_MAX = (GAMMA_W + 1)'(G_LIM);
    localparam logic signed [GAMMA_W:0] G_MIN = -G_MAX;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, UPD, SYND, DECIDE, FINISH, OUT} state_t;

    // Symmetric clamp: the most negative code is never produced, so negation cannot wrap.
    function automatic logic signed [GAMMA_W-1:0] sat_g(input logic signed [GAMMA_W:0] x);
        logic signed [GAMMA_W:0] y;
        if (x > G_MAX)      y = G_MAX;
        else if (x < G_MIN) y = G_MIN;
        else                y = x;
        return y[GAMMA_W-1:0];
    endfunction

    state_t state_q, state_d;

    logic signed [GAMMA_W-1:0] gamma [N];
    logic signed [GAMMA_W-1:0] beta  [N];
    logic signed [MSG_W-1:0]   alpha [M][N];
    logic [N-1:0]              h_rows [M];
    logic [N-1:0]              hard;

    logic [CW-1:0]     col, idx1, nxt_idx1;
    logic [RW-1:0]     row;
    logic [ITER_W-1:0] iter;
    logic [MAG_W-1:0]  min1, min2, nxt_min1, nxt_min2, cur_min1, cur_min2;
    logic              sgn, nxt_sgn, cur_sgn;
    logic [M-1:0]      par, par_next;

    logic last_col, last_row, h_bit, accept, done;

    logic signed [GAMMA_W-1:0] llr_ext, beta_c, gamma_new;
    logic signed [GAMMA_W:0]   ga_ext, al_ext, diff, be_ext, an_ext, sum;
    logic [GAMMA_W-1:0]        beta_abs;
    logic [MAG_W-1:0]          mag, m_sel, m_off;
    logic [MSG_W-1:0]          a_mag;
    logic signed [MSG_W-1:0]   alpha_new;
    logic                      beta_neg, s_upd;

    for (genvar r = 0; r < M; r++) begin : g_hrow
        assign h_rows[r] = H_MATRIX[r*N +: N];
    end

    for (genvar c = 0; c < N; c++) begin : g_hard
        assign hard[c] = gamma[c][GAMMA_W-1];
    end

    assign last_col = (col == CW'(N - 1));
    assign last_row = (row == RW'(M - 1));
    assign h_bit    = h_rows[row][col];
    assign accept   = llr_valid && llr_ready;
    assign done     = (par == '0) || (iter == ITER_W'(MAX_ITER));
    assign llr_ext  = {{(GAMMA_W - LLR_W){llr_in[LLR_W-1]}}, llr_in};

    // Column 0 of a SCAN restarts the min/sign tracking for the new row.
    always_comb begin
        ga_ext   = {gamma[col][GAMMA_W-1], gamma[col]};
        al_ext   = {{(GAMMA_W + 1 - MSG_W){alpha[row][col][MSG_W-1]}}, alpha[row][col]};
        diff     = ga_ext - al_ext;
        beta_c   = sat_g(diff);
        beta_neg = beta_c[GAMMA_W-1];
        beta_abs = beta_neg ? -beta_c : beta_c;
        mag      = (beta_abs > {{(GAMMA_W - MAG_W){1'b0}}, MAX_MAG}) ? MAX_MAG : beta_abs[MAG_W-1:0];
        cur_min1 = (col == '0) ? MAX_MAG : min1;
        cur_min2 = (col == '0) ? MAX_MAG : min2;
        cur_sgn  = (col == '0) ? 1'b0 : sgn;
        nxt_min1 = cur_min1;
        nxt_min2 = cur_min2;
        nxt_idx1 = (col == '0) ? '0 : idx1;
        nxt_sgn  = cur_sgn;
        if (h_bit) begin
            if (mag < cur_min1) begin
                nxt_min2 = cur_min1;
                nxt_min1 = mag;
                nxt_idx1 = col;
            end else if (mag < cur_min2) begin
                nxt_min2 = mag;
            end
            nxt_sgn = cur_sgn ^ beta_neg;
        end
    end

    always_comb begin
        m_sel     = (col == idx1) ? min2 : min1;
        m_off     = (m_sel > OFF_V) ? (m_sel - OFF_V) : '0;
        s_upd     = sgn ^ beta[col][GAMMA_W-1];
        a_mag     = {1'b0, m_off};
        alpha_new = s_upd ? -a_mag : a_mag;
        be_ext    = {beta[col][GAMMA_W-1], beta[col]};
        an_ext    = {{(GAMMA_W + 1 - MSG_W){alpha_new[MSG_W-1]}}, alpha_new};
        sum       = be_ext + an_ext;
        gamma_new = sat_g(sum);
    end

    always_comb begin
        par_next = (col == '0) ? '0 : par;
        for (int r = 0; r < M; r++) begin
            par_next[r] = par_next[r] ^ (h_rows[r][col] & hard[col]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = LOAD;
            LOAD:    if (accept && last_col) state_d = SCAN;
            SCAN:    if (last_col) state_d = UPD;
            UPD:     if (last_col) state_d = last_row ? SYND : SCAN;
            SYND:    if (last_col) state_d = DECIDE;
            DECIDE:  state_d = done ? FINISH : SCAN;
            FINISH:  state_d = OUT;
            OUT:     if (cw_ready) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        llr_ready = (state_q == LOAD);
        cw_valid  = (state_q == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                gamma[c] <= '0;
                beta[c]  <= '0;
            end
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) alpha[r][c] <= '0;
            end
            col        <= '0;
            row        <= '0;
            iter       <= '0;
            min1       <= '0;
            min2       <= '0;
            idx1       <= '0;
            sgn        <= 1'b0;
            par        <= '0;
            codeword   <= '0;
            iterations <= '0;
            converged  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    for (int r = 0; r < M; r++) begin
                        for (int c = 0; c < N; c++) alpha[r][c] <= '0;
                    end
                    row  <= '0;
                    iter <= ITER_W'(1);
                    if (accept) begin
                        gamma[col] <= llr_ext;
                        col        <= last_col ? '0 : col + 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (h_bit) beta[col] <= beta_c;
                    min1 <= nxt_min1;
                    min2 <= nxt_min2;
                    idx1 <= nxt_idx1;
                    sgn  <= nxt_sgn;
                    col  <= last_col ? '0 : col + 1'b1;
                end
                UPD: begin
                    if (h_bit) begin
                        alpha[row][col] <= alpha_new;
                        gamma[col]      <= gamma_new;
                    end
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col) row <= last_row ? '0 : row + 1'b1;
                end
                SYND: begin
                    par <= par_next;
                    col <= last_col ? '0 : col + 1'b1;
                end
                DECIDE: begin
                    if (done) begin
                        codeword   <= hard;
                        iterations <= iter;
                        converged  <= (par == '0);
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                OUT: begin
                    if (cw_ready) busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_layered_oms_decoder.sv
// Scoreboard bench: a behavioural layered min-sum model predicts each frame's result.
// Two decoders are exercised: default parameters, and MAX_ITER=1 / OFFSET=0.
module tb_ldpc_layered_oms_decoder;

    localparam int M = 2;
    localparam int N = 4;
    localparam logic [7:0] H = 8'b1110_1011;

    typedef struct {
        int cw;
        int it;
        int conv;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        llr_in;
    logic [1:0]        llr_valid, llr_ready, cw_valid, cw_ready, converged, busy;
    logic [3:0]        codeword   [2];
    logic [3:0]        iterations [2];

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ldpc_layered_oms_decoder dut0 (
        .clk(clk), .rst(rst),
        .llr_valid(llr_valid[0]), .llr_ready(llr_ready[0]), .llr_in(llr_in),
        .cw_valid(cw_valid[0]), .cw_ready(cw_ready[0]),
        .codeword(codeword[0]), .iterations(iterations[0]),
        .converged(converged[0]), .busy(busy[0])
    );

    ldpc_layered_oms_decoder #(.MAX_ITER(1), .OFFSET(0)) dut1 (
        .clk(clk), .rst(rst),
        .llr_valid(llr_valid[1]), .llr_ready(llr_ready[1]), .llr_in(llr_in),
        .cw_valid(cw_valid[1]), .cw_ready(cw_ready[1]),
        .codeword(codeword[1]), .iterations(iterations[1]),
        .converged(converged[1]), .busy(busy[1])
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 127) return 127;
        if (x < -127) return -127;
        return x;
    endfunction

    function automatic bit h_at(input int r, input int c);
        logic [7:0] hm;
        hm = H;
        return hm[r*N + c];
    endfunction

    // Each check-to-variable message is the min and sign product over the other row members.
    task automatic model(input int llr[4], input int off, input int max_iter, output exp_t e);
        int g[4];
        int a[2][4];
        int b[4];
        int m, s, mag, mo, p, ok;
        for (int c = 0; c < N; c++) begin
            g[c] = llr[c];
            b[c] = 0;
            for (int r = 0; r < M; r++) a[r][c] = 0;
        end
        e.it = 0;
        e.conv = 0;
        for (int it = 1; it <= max_iter; it++) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++)
                    if (h_at(r, c)) b[c] = sat(g[c] - a[r][c]);
                for (int c = 0; c < N; c++) begin
                    if (!h_at(r, c)) continue;
                    m = 15;
                    s = 0;
                    for (int o = 0; o < N; o++) begin
                        if (o == c || !h_at(r, o)) continue;
                        mag = (b[o] < 0) ? -b[o] : b[o];
                        if (mag > 15) mag = 15;
                        if (mag < m) m = mag;
                        if (b[o] < 0) s = s ^ 1;
                    end
                    mo = (m > off) ? m - off : 0;
                    a[r][c] = s ? -mo : mo;
                    g[c] = sat(b[c] + a[r][c]);
                end
            end
            ok = 1;
            for (int r = 0; r < M; r++) begin
                p = 0;
                for (int c = 0; c < N; c++)
                    if (h_at(r, c) && g[c] < 0) p = p ^ 1;
                if (p != 0) ok = 0;
            end
            e.it = it;
            e.conv = ok;
            if (ok) break;
        end
        e.cw = 0;
        for (int c = 0; c < N; c++)
            if (g[c] < 0) e.cw = e.cw | (1 << c);
    endtask

    task automatic applyStimulus(input int sel, input int llr[4], input int gaps, output int ok);
        int cnt;
        ok = 1;
        for (int c = 0; c < N; c++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            llr_in = llr[c][5:0];
            llr_valid[sel] = 1'b1;
            cnt = 0;
            while (!llr_ready[sel] && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 100) begin
                checkOutput("llr_ready_timeout", 0, 1);
                llr_valid[sel] = 1'b0;
                ok = 0;
                return;
            end
            @(negedge clk);
            llr_valid[sel] = 1'b0;
        end
    endtask

    task automatic runFrame(input int sel, input int llr[4], input int gaps, input int hold, input int garbage);
        exp_t e;
        int ok, lat;
        model(llr, (sel == 0) ? 1 : 0, (sel == 0) ? 10 : 1, e);
        exp_q.push_back(e);
        applyStimulus(sel, llr, gaps, ok);
        if (ok == 0) begin
            void'(exp_q.pop_back());
            return;
        end
        checkOutput("busy_decoding", busy[sel], 1);
        if (garbage != 0) begin
            llr_valid[sel] = 1'b1;
            llr_in = 6'b101100;
        end
        lat = 0;
        while (!cw_valid[sel] && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        llr_valid[sel] = 1'b0;
        e = exp_q.pop_front();
        if (lat >= 3000) begin
            checkOutput("cw_valid_timeout", 0, 1);
            return;
        end
        checkOutput("latency", lat, e.it * (2*M*N + N + 1) + 1);
        checkOutput("codeword", codeword[sel], e.cw);
        checkOutput("iterations", iterations[sel], e.it);
        checkOutput("converged", converged[sel], e.conv);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkOutput("hold_cw_valid", cw_valid[sel], 1);
            checkOutput("hold_codeword", codeword[sel], e.cw);
            checkOutput("hold_iterations", iterations[sel], e.it);
            checkOutput("hold_llr_ready", llr_ready[sel], 0);
        end
        cw_ready[sel] = 1'b1;
        @(negedge clk);
        cw_ready[sel] = 1'b0;
        checkOutput("cw_valid_after_hs", cw_valid[sel], 0);
        checkOutput("busy_after_hs", busy[sel], 0);
        checkOutput("llr_ready_after_hs", llr_ready[sel], 1);
    endtask

    task automatic checkReset(input int sel);
        checkOutput("rst_llr_ready", llr_ready[sel], 0);
        checkOutput("rst_cw_valid", cw_valid[sel], 0);
        checkOutput("rst_busy", busy[sel], 0);
        checkOutput("rst_codeword", codeword[sel], 0);
        checkOutput("rst_iterations", iterations[sel], 0);
        checkOutput("rst_converged", converged[sel], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int llr[4];
        int ok;
        rst = 1'b1;
        llr_in = '0;
        llr_valid = '0;
        cw_ready = '0;
        repeat (3) @(negedge clk);
        checkReset(0);
        checkReset(1);
        rst = 1'b0;

        llr = '{5, 5, 5, 5};      runFrame(0, llr, 0, 0, 0);
        llr = '{6, 6, -1, 6};     runFrame(0, llr, 1, 0, 0);
        llr = '{6, 6, -7, 6};     runFrame(0, llr, 0, 5, 1);
        llr = '{-3, -3, 8, 8};    runFrame(0, llr, 0, 0, 0);
        llr = '{-32, 31, -32, 5}; runFrame(0, llr, 1, 0, 0);
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < N; c++) llr[c] = int'($urandom_range(0, 63)) - 32;
            runFrame(0, llr, 1, 0, 0);
        end
        llr = '{-6, 6, -6, -6};   runFrame(0, llr, 0, 0, 0);

        llr = '{6, 6, -7, 6};     runFrame(1, llr, 0, 0, 0);
        llr = '{-3, -3, 8, 8};    runFrame(1, llr, 0, 2, 0);
        llr = '{31, 31, 31, 31};  runFrame(1, llr, 1, 0, 0);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < N; c++) llr[c] = int'($urandom_range(0, 63)) - 32;
            runFrame(1, llr, 0, 0, 0);
        end

        // Abort a frame mid-SCAN, then confirm a clean decode afterwards.
        llr = '{1, -2, 3, -4};
        applyStimulus(0, llr, 0, ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkReset(0);
        checkReset(1);
        rst = 1'b0;
        llr = '{-6, 6, -6, -6};   runFrame(0, llr, 0, 0, 0);
        llr = '{4, -9, 2, 7};     runFrame(0, llr, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
